issue_stage: RTL and testbench
==============================

// Module: issue_stage
// PURPOSE
//  Decode/issue stage sitting between instruction fetch and execute. Decodes the fetched word,
//  tracks in-flight destination registers in a 1-bit-per-register scoreboard, stalls fetch on
//  RAW/WAW hazards and loads a registered issue bundle for execute under a valid/ready handshake.
//  Flush (redirect from execute) kills the held bundle and undoes its scoreboard reservation.
// PARAMETERS
//  NUM_REGS  32   architectural registers tracked; x0 is never busy
// PORTS
//  clk            in   1               clock; all state on rising edge
//  rst_n          in   1               asynchronous, active-low reset
//  if_valid       in   1               fetch presents an instruction
//  if_pc          in   WORD_SIZE       PC of fetched instruction
//  if_instr       in   WORD_SIZE       fetched instruction word
//  if_ready       out  1               stage accepts if_* this cycle (combinational)
//  ex_valid       out  1               issue bundle valid
//  ex_ready       in   1               execute consumes bundle this cycle
//  ex_pc          out  WORD_SIZE       registered PC
//  ex_rs1/ex_rs2  out  ARCH_REG_INDEX_SIZE each   source indices
//  ex_rd          out  ARCH_REG_INDEX_SIZE        destination index
//  ex_imm         out  WORD_SIZE       sign-extended immediate
//  ex_instr_type  out  INSTR_TYPE_SZ   MUL/ALU/MEM/NO_WB class
//  ex_opcode      out  7;  ex_funct3  out 3;  ex_funct7  out 7
//  ex_wr_rd       out  1               bundle writes rd (rd!=0)
//  wb_valid       in   1               writeback retires a register write
//  wb_rd          in   ARCH_REG_INDEX_SIZE        register being written back
//  flush          in   1               kill held bundle; block intake this cycle
// BEHAVIOUR
//  - Reset: ex_valid=0, all ex_* data outputs 0, all busy bits 0.
//  - Decode combinational on if_instr. uses_rs1: ALU, ALU_IMM, LOAD, STORE, BRANCH.
//    uses_rs2: ALU, STORE, BRANCH. wr_rd: (ALU|ALU_IMM|LOAD|AUIPC|JUMP) && rd!=0.
//  - hazard = (uses_rs1&&busy[rs1]) | (uses_rs2&&busy[rs2]) | (wr_rd&&busy[rd]); busy[0]==0 always.
//    Hazard uses registered busy only: reg freed by wb in cycle N is sourceable at issue in N+1.
//  - slot_free = !ex_valid || ex_ready.  if_ready = slot_free && !hazard && !flush.
//  - Issue (if_valid&&if_ready): ex_* <= decoded fields, ex_valid<=1, busy[rd]<=1 if wr_rd.
//    Latency 1: accepted in N -> ex_valid in N+1.
//  - Hold: ex_valid&&!ex_ready -> ex_* stable. ex_valid&&ex_ready&&no issue -> ex_valid<=0.
//  - Writeback: wb_valid -> busy[wb_rd]<=0 (wb_rd==0 ignored). Same-cycle set and clear of the
//    same register cannot occur (issue requires busy==0, wb requires busy==1); clear wins if it does.
//  - Flush: ex_valid<=0 next cycle; if ex_valid&&ex_wr_rd, busy[ex_rd]<=0; ex_ready in the flush
//    cycle is not a transfer. No issue in flush cycle. Other busy bits (older, in execute) kept.
//  - Flush concurrent with wb to another reg: both applied. ex_* data not cleared on flush.
//  - Reset mid-operation: immediate async clear of ex_valid and scoreboard; no partial state.
// STRUCTURE
//  - Constants WORD_SIZE, ARCH_REG_INDEX_SIZE, INSTR_TYPE_SZ, OPCODE_*, INSTR_TYPE_*, MUL_FUNCT7
//    live in defines.sv; nothing new local except uses_rs1/uses_rs2/wr_rd derivation.
//  - Instantiates existing decoder for fields/imm/instr_type.
//  - One sub-module: scoreboard (busy vector; set port, two clear ports wb/flush; 3 read ports).
// TESTING
//  1 ADD x3,x1,x2 then ADD x4,x3,x1, ex_ready=1 -> 2nd stalls (if_ready=0) until wb_rd=3; issues
//    the cycle after wb.
//  2 MUL x5 then ADD x5,x1,x2 (WAW) -> ADD held until wb_rd=5; ADDI x0,x0,0 never sets busy.
//  3 ex_ready=0 for 3 cycles with LW x6 held -> ex_* stable, if_ready=0; ex_ready=1 -> next issues.
//  4 flush with held ADDI x7 (ex_valid=1) -> ex_valid=0 next cycle, busy[7]=0, if_ready=0 in
//    flush cycle; dependent ADD x8,x7,x1 then issues without stall.
//  5 SW x2,0(x1), BEQ x1,x2 -> ex_wr_rd=0, no busy set; JAL x1 sets busy[1]; AUIPC x9 imm=U.
//  6 rst_n low mid-stall with busy[3]=1 -> ex_valid=0, busy all 0 immediately; assert wb to a
//    non-busy register never occurs.

Source files
------------

// File: rtl/issue_stage_pkg.sv
// Shared widths, opcode/class encodings, the issue bundle layout and the combinational
// instruction decoder used by the issue stage.
package issue_stage_pkg;

    localparam int WORD_SIZE           = 32;
    localparam int ARCH_REG_INDEX_SIZE = 5;
    localparam int INSTR_TYPE_SZ       = 2;

    localparam logic [6:0] OPCODE_ALU     = 7'b0110011;
    localparam logic [6:0] OPCODE_ALU_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD    = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE   = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPCODE_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPCODE_JUMP    = 7'b1101111;
    localparam logic [6:0] MUL_FUNCT7     = 7'b0000001;

    typedef enum logic [INSTR_TYPE_SZ-1:0] {
        INSTR_TYPE_ALU   = 2'd0,
        INSTR_TYPE_MUL   = 2'd1,
        INSTR_TYPE_MEM   = 2'd2,
        INSTR_TYPE_NO_WB = 2'd3
    } instr_type_e;

    typedef struct packed {
        logic [ARCH_REG_INDEX_SIZE-1:0] rs1;
        logic [ARCH_REG_INDEX_SIZE-1:0] rs2;
        logic [ARCH_REG_INDEX_SIZE-1:0] rd;
        logic [WORD_SIZE-1:0]           imm;
        instr_type_e                    instr_type;
        logic [6:0]                     opcode;
        logic [2:0]                     funct3;
        logic [6:0]                     funct7;
        logic                           uses_rs1;
        logic                           uses_rs2;
        logic                           wr_rd;
    } decoded_t;

    typedef struct packed {
        logic [WORD_SIZE-1:0]           pc;
        logic [ARCH_REG_INDEX_SIZE-1:0] rs1;
        logic [ARCH_REG_INDEX_SIZE-1:0] rs2;
        logic [ARCH_REG_INDEX_SIZE-1:0] rd;
        logic [WORD_SIZE-1:0]           imm;
        logic [INSTR_TYPE_SZ-1:0]       instr_type;
        logic [6:0]                     opcode;
        logic [2:0]                     funct3;
        logic [6:0]                     funct7;
        logic                           wr_rd;
    } ex_bundle_t;

    function automatic decoded_t decode(input logic [WORD_SIZE-1:0] instr);
        decoded_t d;
        logic     wb_class;
        d            = '0;
        d.opcode     = instr[6:0];
        d.rd         = instr[11:7];
        d.funct3     = instr[14:12];
        d.rs1        = instr[19:15];
        d.rs2        = instr[24:20];
        d.funct7     = instr[31:25];
        d.instr_type = INSTR_TYPE_NO_WB;
        wb_class     = 1'b0;
        case (d.opcode)
            OPCODE_ALU: begin
                d.uses_rs1   = 1'b1;
                d.uses_rs2   = 1'b1;
                wb_class     = 1'b1;
                d.instr_type = (d.funct7 == MUL_FUNCT7) ? INSTR_TYPE_MUL : INSTR_TYPE_ALU;
            end
            OPCODE_ALU_IMM: begin
                d.uses_rs1   = 1'b1;
                wb_class     = 1'b1;
                d.instr_type = INSTR_TYPE_ALU;
                d.imm        = {{20{instr[31]}}, instr[31:20]};
            end
            OPCODE_LOAD: begin
                d.uses_rs1   = 1'b1;
                wb_class     = 1'b1;
                d.instr_type = INSTR_TYPE_MEM;
                d.imm        = {{20{instr[31]}}, instr[31:20]};
            end
            OPCODE_STORE: begin
                d.uses_rs1   = 1'b1;
                d.uses_rs2   = 1'b1;
                d.instr_type = INSTR_TYPE_MEM;
                d.imm        = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPCODE_BRANCH: begin
                d.uses_rs1   = 1'b1;
                d.uses_rs2   = 1'b1;
                d.imm        = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                instr[11:8], 1'b0};
            end
            OPCODE_AUIPC: begin
                wb_class     = 1'b1;
                d.instr_type = INSTR_TYPE_ALU;
                d.imm        = {instr[31:12], 12'b0};
            end
            OPCODE_JUMP: begin
                wb_class     = 1'b1;
                d.instr_type = INSTR_TYPE_ALU;
                d.imm        = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                instr[30:21], 1'b0};
            end
            default: ;
        endcase
        // x0 is hardwired, so writes to it never need tracking
        d.wr_rd = wb_class && (d.rd != '0);
        return d;
    endfunction

endpackage

// File: rtl/issue_stage_scoreboard.sv
// One busy bit per architectural register: set on issue, cleared by writeback or by
// flushing the held bundle. Register 0 is never busy.
module issue_stage_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic             wb_clr_en,
    input  logic [IDX_W-1:0] wb_clr_idx,
    input  logic             fl_clr_en,
    input  logic [IDX_W-1:0] fl_clr_idx,
    input  logic [IDX_W-1:0] rd_idx_a,
    input  logic [IDX_W-1:0] rd_idx_b,
    input  logic [IDX_W-1:0] rd_idx_c,
    output logic             busy_a,
    output logic             busy_b,
    output logic             busy_c
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // clears are applied after the set so a clear wins on a collision
    always_comb begin
        busy_d = busy_q;
        if (set_en) busy_d[set_idx] = 1'b1;
        if (wb_clr_en) busy_d[wb_clr_idx] = 1'b0;
        if (fl_clr_en) busy_d[fl_clr_idx] = 1'b0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign busy_a = busy_q[rd_idx_a];
    assign busy_b = busy_q[rd_idx_b];
    assign busy_c = busy_q[rd_idx_c];

endmodule

// File: rtl/issue_stage.sv
// Decode/issue stage: decodes the fetched word, stalls on RAW/WAW against the scoreboard
// and holds a registered issue bundle for execute under valid/ready.
module issue_stage
    import issue_stage_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           if_valid,
    input  logic [WORD_SIZE-1:0]           if_pc,
    input  logic [WORD_SIZE-1:0]           if_instr,
    output logic                           if_ready,
    output logic                           ex_valid,
    input  logic                           ex_ready,
    output logic [WORD_SIZE-1:0]           ex_pc,
    output logic [ARCH_REG_INDEX_SIZE-1:0] ex_rs1,
    output logic [ARCH_REG_INDEX_SIZE-1:0] ex_rs2,
    output logic [ARCH_REG_INDEX_SIZE-1:0] ex_rd,
    output logic [WORD_SIZE-1:0]           ex_imm,
    output logic [INSTR_TYPE_SZ-1:0]       ex_instr_type,
    output logic [6:0]                     ex_opcode,
    output logic [2:0]                     ex_funct3,
    output logic [6:0]                     ex_funct7,
    output logic                           ex_wr_rd,
    input  logic                           wb_valid,
    input  logic [ARCH_REG_INDEX_SIZE-1:0] wb_rd,
    input  logic                           flush
);

    decoded_t   dec;
    ex_bundle_t bundle_q, bundle_d;
    logic       ex_valid_q, ex_valid_d;
    logic       busy_rs1, busy_rs2, busy_rd;
    logic       hazard, slot_free, issue, flush_clr;

    assign dec = decode(if_instr);

    issue_stage_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (ARCH_REG_INDEX_SIZE)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_en     (issue && dec.wr_rd),
        .set_idx    (dec.rd),
        .wb_clr_en  (wb_valid),
        .wb_clr_idx (wb_rd),
        .fl_clr_en  (flush_clr),
        .fl_clr_idx (bundle_q.rd),
        .rd_idx_a   (dec.rs1),
        .rd_idx_b   (dec.rs2),
        .rd_idx_c   (dec.rd),
        .busy_a     (busy_rs1),
        .busy_b     (busy_rs2),
        .busy_c     (busy_rd)
    );

    assign hazard    = (dec.uses_rs1 && busy_rs1) || (dec.uses_rs2 && busy_rs2) ||
                       (dec.wr_rd && busy_rd);
    assign slot_free = !ex_valid_q || ex_ready;
    assign if_ready  = slot_free && !hazard && !flush;
    assign issue     = if_valid && if_ready;
    // only a still-held bundle owns a reservation worth undoing
    assign flush_clr = flush && ex_valid_q && bundle_q.wr_rd;

    always_comb begin
        bundle_d   = bundle_q;
        ex_valid_d = ex_valid_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (issue) begin
            ex_valid_d          = 1'b1;
            bundle_d.pc         = if_pc;
            bundle_d.rs1        = dec.rs1;
            bundle_d.rs2        = dec.rs2;
            bundle_d.rd         = dec.rd;
            bundle_d.imm        = dec.imm;
            bundle_d.instr_type = dec.instr_type;
            bundle_d.opcode     = dec.opcode;
            bundle_d.funct3     = dec.funct3;
            bundle_d.funct7     = dec.funct7;
            bundle_d.wr_rd      = dec.wr_rd;
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            bundle_q   <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            bundle_q   <= bundle_d;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_pc         = bundle_q.pc;
    assign ex_rs1        = bundle_q.rs1;
    assign ex_rs2        = bundle_q.rs2;
    assign ex_rd         = bundle_q.rd;
    assign ex_imm        = bundle_q.imm;
    assign ex_instr_type = bundle_q.instr_type;
    assign ex_opcode     = bundle_q.opcode;
    assign ex_funct3     = bundle_q.funct3;
    assign ex_funct7     = bundle_q.funct7;
    assign ex_wr_rd      = bundle_q.wr_rd;

endmodule

// File: tb/tb_issue_stage.sv
// Bench for issue_stage: assembly-level reference model checked every cycle, plus
// hand-computed literal checks for each directed scenario.
module tb_issue_stage;
    import issue_stage_pkg::*;

    localparam int C_NONE = 0, C_ALU = 1, C_ALUI = 2, C_LOAD = 3, C_STORE = 4,
                   C_BRANCH = 5, C_JAL = 6, C_AUIPC = 7;

    typedef struct {
        logic [31:0] word, pc, imm, rd, rs1, rs2, f3, f7, itype, op;
        bit ur1, ur2, wr, has_rd, has_f3, has_f7;
    } insn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid, ex_ready, wb_valid, flush;
    logic [31:0] if_pc, if_instr;
    logic [4:0]  wb_rd;
    logic        if_ready, ex_valid, ex_wr_rd;
    logic [31:0] ex_pc, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [1:0]  ex_instr_type;
    logic [6:0]  ex_opcode, ex_funct7;
    logic [2:0]  ex_funct3;

    int n_vec = 0;
    int n_err = 0;

    insn_t cur;
    insn_t m_ex;
    bit    m_valid;
    bit    m_busy [32];

    always #5 clk = ~clk;

    issue_stage dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .if_ready(if_ready), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_imm(ex_imm),
        .ex_instr_type(ex_instr_type), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
        .ex_funct7(ex_funct7), .ex_wr_rd(ex_wr_rd), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .flush(flush)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic insn_t mk(input int cls, input logic [31:0] pc, input int rd,
                                 input int rs1, input int rs2, input logic [31:0] imm,
                                 input int f3, input int f7);
        insn_t       x;
        logic [4:0]  d5, s1, s2;
        logic [2:0]  f3b;
        logic [6:0]  f7b;
        d5  = rd[4:0];
        s1  = rs1[4:0];
        s2  = rs2[4:0];
        f3b = f3[2:0];
        f7b = f7[6:0];
        x = '{default: '0};
        x.pc  = pc; x.rd = 32'(rd); x.rs1 = 32'(rs1); x.rs2 = 32'(rs2);
        x.f3  = 32'(f3); x.f7 = 32'(f7); x.imm = imm;
        x.itype = 32'(INSTR_TYPE_ALU);
        case (cls)
            C_ALU: begin
                x.op = 32'(OPCODE_ALU); x.imm = 0;
                x.word = {f7b, s2, s1, f3b, d5, OPCODE_ALU};
                if (f7b == MUL_FUNCT7) x.itype = 32'(INSTR_TYPE_MUL);
            end
            C_ALUI:   begin x.op = 32'(OPCODE_ALU_IMM); x.word = {imm[11:0], s1, f3b, d5, OPCODE_ALU_IMM}; end
            C_LOAD:   begin x.op = 32'(OPCODE_LOAD); x.itype = 32'(INSTR_TYPE_MEM);
                            x.word = {imm[11:0], s1, f3b, d5, OPCODE_LOAD}; end
            C_STORE:  begin x.op = 32'(OPCODE_STORE); x.itype = 32'(INSTR_TYPE_MEM);
                            x.word = {imm[11:5], s2, s1, f3b, imm[4:0], OPCODE_STORE}; end
            C_BRANCH: begin x.op = 32'(OPCODE_BRANCH); x.itype = 32'(INSTR_TYPE_NO_WB);
                            x.word = {imm[12], imm[10:5], s2, s1, f3b, imm[4:1], imm[11], OPCODE_BRANCH}; end
            C_JAL:    begin x.op = 32'(OPCODE_JUMP);
                            x.word = {imm[20], imm[10:1], imm[11], imm[19:12], d5, OPCODE_JUMP}; end
            C_AUIPC:  begin x.op = 32'(OPCODE_AUIPC); x.word = {imm[31:12], d5, OPCODE_AUIPC}; end
            default:  begin x.itype = 32'(INSTR_TYPE_NO_WB); end
        endcase
        x.ur1    = cls inside {C_ALU, C_ALUI, C_LOAD, C_STORE, C_BRANCH};
        x.ur2    = cls inside {C_ALU, C_STORE, C_BRANCH};
        x.wr     = (cls inside {C_ALU, C_ALUI, C_LOAD, C_AUIPC, C_JAL}) && (rd != 0);
        x.has_rd = cls inside {C_ALU, C_ALUI, C_LOAD, C_AUIPC, C_JAL};
        x.has_f3 = cls inside {C_ALU, C_ALUI, C_LOAD, C_STORE, C_BRANCH};
        x.has_f7 = (cls == C_ALU);
        return x;
    endfunction

    function automatic insn_t i_add(input logic [31:0] pc, input int rd, input int a, input int b);
        return mk(C_ALU, pc, rd, a, b, 0, 0, 0);
    endfunction
    function automatic insn_t i_mul(input logic [31:0] pc, input int rd, input int a, input int b);
        return mk(C_ALU, pc, rd, a, b, 0, 0, 1);
    endfunction

    // Reference model: evaluated on the falling edge with the inputs the next rising edge sees.
    always @(negedge clk) begin
        bit haz, slot, ifr, issue;
        if (!rst_n) begin
            chk("rst_ex_valid", 32'(ex_valid), 0);
            chk("rst_ex_pc", ex_pc, 0);
            chk("rst_ex_imm", ex_imm, 0);
            chk("rst_ex_rd_wr", {26'd0, ex_rd, ex_wr_rd}, 0);
            m_valid = 0;
            foreach (m_busy[i]) m_busy[i] = 0;
        end else begin
            haz  = (cur.ur1 && m_busy[cur.rs1]) || (cur.ur2 && m_busy[cur.rs2]) ||
                   (cur.wr && m_busy[cur.rd]);
            slot = !m_valid || ex_ready;
            ifr  = slot && !haz && !flush;
            chk("if_ready", 32'(if_ready), 32'(ifr));
            chk("ex_valid", 32'(ex_valid), 32'(m_valid));
            if (m_valid) begin
                chk("ex_pc", ex_pc, m_ex.pc);
                chk("ex_imm", ex_imm, m_ex.imm);
                chk("ex_opcode", 32'(ex_opcode), m_ex.op);
                chk("ex_type", 32'(ex_instr_type), m_ex.itype);
                chk("ex_wr_rd", 32'(ex_wr_rd), 32'(m_ex.wr));
                if (m_ex.ur1)    chk("ex_rs1", 32'(ex_rs1), m_ex.rs1);
                if (m_ex.ur2)    chk("ex_rs2", 32'(ex_rs2), m_ex.rs2);
                if (m_ex.has_rd) chk("ex_rd", 32'(ex_rd), m_ex.rd);
                if (m_ex.has_f3) chk("ex_funct3", 32'(ex_funct3), m_ex.f3);
                if (m_ex.has_f7) chk("ex_funct7", 32'(ex_funct7), m_ex.f7);
            end
            if (wb_valid && wb_rd != 0) chk("wb_target_busy", 32'(m_busy[wb_rd]), 1);
            issue = if_valid && ifr;
            if (issue && cur.wr) m_busy[cur.rd] = 1;
            if (flush && m_valid && m_ex.wr) m_busy[m_ex.rd] = 0;
            if (wb_valid) m_busy[wb_rd] = 0;
            m_busy[0] = 0;
            if (flush)         m_valid = 0;
            else if (issue)    begin m_valid = 1; m_ex = cur; end
            else if (ex_ready) m_valid = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input insn_t x);
        cur      = x;
        if_instr = x.word;
        if_pc    = x.pc;
        if_valid = 1'b1;
    endtask

    task automatic wb(input int r);
        wb_valid = 1'b1;
        wb_rd    = r[4:0];
        tick();
        wb_valid = 1'b0;
    endtask

    initial begin
        cur      = '{default: '0};
        m_ex     = '{default: '0};
        rst_n    = 1'b0;
        if_valid = 1'b0; if_pc = 0; if_instr = 0;
        ex_ready = 1'b1; wb_valid = 1'b0; wb_rd = 0; flush = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        #1;

        // 1: RAW on x3 stalls until the cycle after writeback
        present(i_add(32'h100, 3, 1, 2));
        #1 chk("t1_first_ready", 32'(if_ready), 1);
        tick();
        present(i_add(32'h104, 4, 3, 1));
        #1 chk("t1_raw_stall", 32'(if_ready), 0);
        chk("t1_ex_rd", 32'(ex_rd), 3);
        tick();
        chk("t1_still_stall", 32'(if_ready), 0);
        wb_valid = 1'b1; wb_rd = 5'd3;
        #1 chk("t1_wb_cycle_stall", 32'(if_ready), 0);
        tick();
        wb_valid = 1'b0;
        #1 chk("t1_after_wb", 32'(if_ready), 1);
        tick();
        if_valid = 1'b0;
        chk("t1_issued_rs1", 32'(ex_rs1), 3);
        chk("t1_issued_pc", ex_pc, 32'h104);
        wb(4);

        // 2: WAW on x5, then ADDI x0 reserves nothing
        present(i_mul(32'h200, 5, 1, 2));
        tick();
        chk("t2_mul_type", 32'(ex_instr_type), 32'(INSTR_TYPE_MUL));
        present(i_add(32'h204, 5, 1, 2));
        #1 chk("t2_waw_stall", 32'(if_ready), 0);
        tick(); tick();
        wb(5);
        #1 chk("t2_waw_release", 32'(if_ready), 1);
        tick();
        present(mk(C_ALUI, 32'h208, 0, 0, 0, 0, 0, 0));
        #1 chk("t2_addi_ready", 32'(if_ready), 1);
        tick();
        if_valid = 1'b0;
        chk("t2_x0_no_wr", 32'(ex_wr_rd), 0);
        wb(5);

        // 3: held LW x6 under backpressure
        ex_ready = 1'b0;
        present(mk(C_LOAD, 32'h300, 6, 1, 0, 32'd4, 2, 0));
        tick();
        present(i_add(32'h304, 12, 1, 2));
        for (int i = 0; i < 3; i++) begin
            #1 chk("t3_hold_ready", 32'(if_ready), 0);
            chk("t3_hold_pc", ex_pc, 32'h300);
            chk("t3_hold_imm", ex_imm, 32'd4);
            tick();
        end
        ex_ready = 1'b1;
        #1 chk("t3_release", 32'(if_ready), 1);
        tick();
        if_valid = 1'b0;
        chk("t3_next_pc", ex_pc, 32'h304);
        wb(6); wb(12);

        // 4: flush of held ADDI x7 frees x7 for the dependent ADD
        ex_ready = 1'b0;
        present(mk(C_ALUI, 32'h400, 7, 1, 0, 32'd1, 0, 0));
        tick();
        ex_ready = 1'b1;
        flush    = 1'b1;
        present(i_add(32'h404, 8, 7, 1));
        #1 chk("t4_flush_blocks", 32'(if_ready), 0);
        tick();
        flush = 1'b0;
        #1 chk("t4_flushed_valid", 32'(ex_valid), 0);
        chk("t4_dep_no_stall", 32'(if_ready), 1);
        tick();
        if_valid = 1'b0;
        chk("t4_dep_pc", ex_pc, 32'h404);
        wb(8);

        // 5: store/branch write nothing, JAL x1 reserves x1, AUIPC U-immediate
        present(mk(C_STORE, 32'h500, 0, 1, 2, 32'hFFFF_FFFC, 2, 0));
        tick();
        if_valid = 1'b0;
        chk("t5_sw_imm", ex_imm, 32'hFFFF_FFFC);
        chk("t5_sw_wr", 32'(ex_wr_rd), 0);
        present(mk(C_BRANCH, 32'h504, 0, 1, 2, 32'hFFFF_FFF8, 0, 0));
        tick();
        if_valid = 1'b0;
        chk("t5_beq_imm", ex_imm, 32'hFFFF_FFF8);
        chk("t5_beq_wr", 32'(ex_wr_rd), 0);
        present(mk(C_JAL, 32'h508, 1, 0, 0, 32'h800, 0, 0));
        tick();
        chk("t5_jal_imm", ex_imm, 32'h800);
        chk("t5_jal_wr", 32'(ex_wr_rd), 1);
        present(i_add(32'h50C, 13, 1, 2));
        #1 chk("t5_x1_busy", 32'(if_ready), 0);
        wb(1);
        #1 chk("t5_x1_free", 32'(if_ready), 1);
        tick();
        present(mk(C_AUIPC, 32'h510, 9, 0, 0, 32'h1234_5000, 0, 0));
        tick();
        if_valid = 1'b0;
        chk("t5_auipc_imm", ex_imm, 32'h1234_5000);
        chk("t5_auipc_rd", 32'(ex_rd), 9);
        wb(13); wb(9);

        // 6: asynchronous reset in the middle of a stall
        ex_ready = 1'b0;
        present(i_add(32'h600, 3, 1, 2));
        tick();
        present(i_add(32'h604, 4, 3, 1));
        #1 chk("t6_stall", 32'(if_ready), 0);
        tick();
        #2 rst_n = 1'b0;
        #1 chk("t6_async_valid", 32'(ex_valid), 0);
        chk("t6_async_pc", ex_pc, 0);
        tick(); tick();
        rst_n    = 1'b1;
        ex_ready = 1'b1;
        #1 chk("t6_busy_cleared", 32'(if_ready), 1);
        tick();
        if_valid = 1'b0;
        chk("t6_reissue_pc", ex_pc, 32'h604);
        wb(4);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
